// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: arbitrates EX exceptions and interrupts, flushes, updates CSRs, redirects PC.
// Optional macro TRAP_VECTORED_EN: vectored mtvec mode (mode bits 2'b01) for interrupts.
module trap_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic        illegal_ops_ex_i,
    input  logic        ecall_ex_i,
    input  logic        ebreak_ex_i,
    input  logic        mret_ex_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] inst_ex_i,
    input  logic        ext_irq_i,
    input  logic        tmr_irq_i,
    input  logic        sw_irq_i,
    input  logic        csr_mstatus_mie_i,
    input  logic        csr_meie_i,
    input  logic        csr_mtie_i,
    input  logic        csr_msie_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    output logic        g_exception_o,
    output logic        trap_busy_o,
    output logic        pipe_stall_o,
    output logic        pipe_flush_o,
    output logic        trap_csr_we_o,
    output logic [31:0] mepc_wdata_o,
    output logic [31:0] mcause_wdata_o,
    output logic [31:0] mtval_wdata_o,
    output logic        mstatus_trap_o,
    output logic        mstatus_mret_o,
    output logic        pc_redirect_o,
    output logic [31:0] pc_redirect_addr_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, FLUSH, CSRW, REDIR} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_mret_q, is_mret_d;
    logic              is_irq_q, is_irq_d;
    logic [XLEN-1:0]   mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic              g_exc_q, g_exc_d, busy_q, busy_d, stall_q, stall_d, flush_q, flush_d;
    logic              csr_we_q, csr_we_d, mtrap_q, mtrap_d, mret_p_q, mret_p_d;
    logic              redir_q, redir_d;
    logic [XLEN-1:0]   redir_addr_q, redir_addr_d;

    logic              exc_c, irq_ext_c, irq_sw_c, irq_tmr_c, irq_any_c;
    logic [XLEN-1:0]   trap_base_c, ret_base_c, trap_target_c;

    assign exc_c       = illegal_ops_ex_i | ecall_ex_i | ebreak_ex_i;
    assign irq_ext_c   = csr_mstatus_mie_i & ext_irq_i & csr_meie_i;
    assign irq_sw_c    = csr_mstatus_mie_i & sw_irq_i  & csr_msie_i;
    assign irq_tmr_c   = csr_mstatus_mie_i & tmr_irq_i & csr_mtie_i;
    assign irq_any_c   = irq_ext_c | irq_sw_c | irq_tmr_c;
    assign trap_base_c = csr_mtvec_i & ~XLEN'(3);
    assign ret_base_c  = csr_mepc_i  & ~XLEN'(3);

    // Interrupts may dispatch to base + 4*cause when mtvec selects vectored mode
`ifdef TRAP_VECTORED_EN
    assign trap_target_c = (is_irq_q && csr_mtvec_i[1:0] == 2'b01)
                         ? trap_base_c + {mcause_q[29:0], 2'b00} : trap_base_c;
`else
    assign trap_target_c = trap_base_c;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_mret_d    = is_mret_q;
        is_irq_d     = is_irq_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        g_exc_d      = 1'b0;
        redir_addr_d = '0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid_i && (exc_c || irq_any_c || mret_ex_i)) begin
                    state_d   = FLUSH;
                    cnt_d     = CNT_W'(FLUSH_CYCLES);
                    g_exc_d   = exc_c | irq_any_c;
                    is_mret_d = ~(exc_c | irq_any_c);
                    is_irq_d  = ~exc_c & irq_any_c;
                    if (exc_c || irq_any_c) begin
                        mepc_d  = pc_ex_i;
                        mtval_d = '0;
                        if (illegal_ops_ex_i) begin
                            mcause_d = XLEN'(2);
                            mtval_d  = inst_ex_i;
                        end else if (ecall_ex_i) begin
                            mcause_d = XLEN'(11);
                        end else if (ebreak_ex_i) begin
                            mcause_d = XLEN'(3);
                            mtval_d  = pc_ex_i;
                        end else if (irq_ext_c) begin
                            mcause_d = 32'h8000_000B;
                        end else if (irq_sw_c) begin
                            mcause_d = 32'h8000_0003;
                        end else begin
                            mcause_d = 32'h8000_0007;
                        end
                    end
                end
            end
            FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = is_mret_q ? REDIR : CSRW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CSRW:    state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies
        busy_d   = (state_d != IDLE);
        stall_d  = busy_d;
        flush_d  = (state_d == FLUSH);
        csr_we_d = (state_d == CSRW);
        mtrap_d  = (state_d == CSRW);
        redir_d  = (state_d == REDIR);
        mret_p_d = (state_d == REDIR) && is_mret_d;
        if (state_d == REDIR) begin
            redir_addr_d = is_mret_d ? ret_base_c : trap_target_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_mret_q    <= 1'b0;
            is_irq_q     <= 1'b0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            g_exc_q      <= 1'b0;
            busy_q       <= 1'b0;
            stall_q      <= 1'b0;
            flush_q      <= 1'b0;
            csr_we_q     <= 1'b0;
            mtrap_q      <= 1'b0;
            mret_p_q     <= 1'b0;
            redir_q      <= 1'b0;
            redir_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_mret_q    <= is_mret_d;
            is_irq_q     <= is_irq_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
            g_exc_q      <= g_exc_d;
            busy_q       <= busy_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            csr_we_q     <= csr_we_d;
            mtrap_q      <= mtrap_d;
            mret_p_q     <= mret_p_d;
            redir_q      <= redir_d;
            redir_addr_q <= redir_addr_d;
        end
    end

    assign g_exception_o      = g_exc_q;
    assign trap_busy_o        = busy_q;
    assign pipe_stall_o       = stall_q;
    assign pipe_flush_o       = flush_q;
    assign trap_csr_we_o      = csr_we_q;
    assign mepc_wdata_o       = mepc_q;
    assign mcause_wdata_o     = mcause_q;
    assign mtval_wdata_o      = mtval_q;
    assign mstatus_trap_o     = mtrap_q;
    assign mstatus_mret_o     = mret_p_q;
    assign pc_redirect_o      = redir_q;
    assign pc_redirect_addr_o = redir_addr_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer (FLUSH_CYCLES=2); expected redirect for vectored case follows TRAP_VECTORED_EN.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, illegal, ecall, ebreak, mret;
    logic [31:0] pc_ex, inst_ex;
    logic        ext_irq, tmr_irq, sw_irq;
    logic        mie, meie, mtie, msie;
    logic [31:0] mtvec, mepc;
    logic        g_exception, trap_busy, pipe_stall, pipe_flush, trap_csr_we;
    logic [31:0] mepc_wdata, mcause_wdata, mtval_wdata;
    logic        mstatus_trap, mstatus_mret, pc_redirect;
    logic [31:0] pc_redirect_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .illegal_ops_ex_i(illegal), .ecall_ex_i(ecall),
        .ebreak_ex_i(ebreak), .mret_ex_i(mret), .pc_ex_i(pc_ex), .inst_ex_i(inst_ex),
        .ext_irq_i(ext_irq), .tmr_irq_i(tmr_irq), .sw_irq_i(sw_irq),
        .csr_mstatus_mie_i(mie), .csr_meie_i(meie), .csr_mtie_i(mtie), .csr_msie_i(msie),
        .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
        .g_exception_o(g_exception), .trap_busy_o(trap_busy), .pipe_stall_o(pipe_stall),
        .pipe_flush_o(pipe_flush), .trap_csr_we_o(trap_csr_we),
        .mepc_wdata_o(mepc_wdata), .mcause_wdata_o(mcause_wdata), .mtval_wdata_o(mtval_wdata),
        .mstatus_trap_o(mstatus_trap), .mstatus_mret_o(mstatus_mret),
        .pc_redirect_o(pc_redirect), .pc_redirect_addr_o(pc_redirect_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        ex_valid = 0; illegal = 0; ecall = 0; ebreak = 0; mret = 0;
        ext_irq = 0; tmr_irq = 0; sw_irq = 0;
    endtask

    // Request already driven; walks accept -> FLUSH x2 -> CSRW -> REDIR -> IDLE
    task automatic trap_seq(input string tag, input logic [31:0] e_mepc, input logic [31:0] e_mcause,
                            input logic [31:0] e_mtval, input logic [31:0] e_addr);
        tick();
        check_eq({tag, "_gexc1"},  32'(g_exception), 32'd1);
        check_eq({tag, "_flush1"}, 32'(pipe_flush), 32'd1);
        check_eq({tag, "_busy1"},  32'(trap_busy), 32'd1);
        check_eq({tag, "_we1"},    32'(trap_csr_we), 32'd0);
        clear_req();
        tick();
        check_eq({tag, "_gexc2"},  32'(g_exception), 32'd0);
        check_eq({tag, "_flush2"}, 32'(pipe_flush), 32'd1);
        check_eq({tag, "_stall2"}, 32'(pipe_stall), 32'd1);
        tick();
        check_eq({tag, "_flush3"}, 32'(pipe_flush), 32'd0);
        check_eq({tag, "_we3"},    32'(trap_csr_we), 32'd1);
        check_eq({tag, "_mstr3"},  32'(mstatus_trap), 32'd1);
        check_eq({tag, "_stall3"}, 32'(pipe_stall), 32'd1);
        check_eq({tag, "_redir3"}, 32'(pc_redirect), 32'd0);
        check_eq({tag, "_mepc"},   mepc_wdata, e_mepc);
        check_eq({tag, "_mcause"}, mcause_wdata, e_mcause);
        check_eq({tag, "_mtval"},  mtval_wdata, e_mtval);
        tick();
        check_eq({tag, "_redir4"}, 32'(pc_redirect), 32'd1);
        check_eq({tag, "_addr4"},  pc_redirect_addr, e_addr);
        check_eq({tag, "_we4"},    32'(trap_csr_we), 32'd0);
        check_eq({tag, "_mret4"},  32'(mstatus_mret), 32'd0);
        check_eq({tag, "_stall4"}, 32'(pipe_stall), 32'd1);
        tick();
        check_eq({tag, "_busy5"},  32'(trap_busy), 32'd0);
        check_eq({tag, "_redir5"}, 32'(pc_redirect), 32'd0);
        check_eq({tag, "_hold5"},  mcause_wdata, e_mcause);
    endtask

    initial begin
        rst_n = 0;
        clear_req();
        pc_ex = 0; inst_ex = 0;
        mie = 0; meie = 0; mtie = 0; msie = 0;
        mtvec = 32'h200; mepc = 0;
        #1;
        check_eq("rst_busy",  32'(trap_busy), 32'd0);
        check_eq("rst_flush", 32'(pipe_flush), 32'd0);
        check_eq("rst_mcause", mcause_wdata, 32'd0);
        repeat (2) tick();
        rst_n = 1;
        tick();
        check_eq("idle_stall", 32'(pipe_stall), 32'd0);

        // Illegal op
        ex_valid = 1; illegal = 1; pc_ex = 32'h100; inst_ex = 32'hFFFF_FFFF;
        trap_seq("illegal", 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h200);

        // Priority: illegal beats ecall and ext_irq
        mie = 1; meie = 1;
        ex_valid = 1; illegal = 1; ecall = 1; ext_irq = 1; pc_ex = 32'h140; inst_ex = 32'h0000_0013;
        trap_seq("prio_ill", 32'h140, 32'd2, 32'h0000_0013, 32'h200);

        // ecall beats timer interrupt
        mtie = 1;
        ex_valid = 1; ecall = 1; tmr_irq = 1; pc_ex = 32'h180;
        trap_seq("prio_ecall", 32'h180, 32'd11, 32'd0, 32'h200);

        // software beats timer
        msie = 1;
        ex_valid = 1; sw_irq = 1; tmr_irq = 1; pc_ex = 32'h1C0;
        trap_seq("prio_sw", 32'h1C0, 32'h8000_0003, 32'd0, 32'h200);

        // ebreak records pc as mtval
        ex_valid = 1; ebreak = 1; pc_ex = 32'h244;
        trap_seq("ebreak", 32'h244, 32'd3, 32'h244, 32'h200);

        // Masking by mstatus.MIE
        mie = 0; msie = 0; meie = 0; mtie = 1;
        ex_valid = 1; tmr_irq = 1; pc_ex = 32'h300;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("mask_busy", 32'(trap_busy), 32'd0);
            check_eq("mask_gexc", 32'(g_exception), 32'd0);
        end
        mie = 1;
        trap_seq("tmr", 32'h300, 32'h8000_0007, 32'd0, 32'h200);

        // mret
        mepc = 32'h1234;
        ex_valid = 1; mret = 1;
        tick();
        check_eq("mret_gexc1",  32'(g_exception), 32'd0);
        check_eq("mret_flush1", 32'(pipe_flush), 32'd1);
        check_eq("mret_we1",    32'(trap_csr_we), 32'd0);
        clear_req();
        tick();
        check_eq("mret_flush2", 32'(pipe_flush), 32'd1);
        check_eq("mret_we2",    32'(trap_csr_we), 32'd0);
        tick();
        check_eq("mret_redir3", 32'(pc_redirect), 32'd1);
        check_eq("mret_addr3",  pc_redirect_addr, 32'h1234);
        check_eq("mret_pulse3", 32'(mstatus_mret), 32'd1);
        check_eq("mret_we3",    32'(trap_csr_we), 32'd0);
        check_eq("mret_mstr3",  32'(mstatus_trap), 32'd0);
        tick();
        check_eq("mret_busy4",  32'(trap_busy), 32'd0);
        check_eq("mret_pulse4", 32'(mstatus_mret), 32'd0);

        // mret + illegal: illegal trap only
        ex_valid = 1; mret = 1; illegal = 1; pc_ex = 32'h400; inst_ex = 32'hDEAD_BEEF;
        trap_seq("mret_ill", 32'h400, 32'd2, 32'hDEAD_BEEF, 32'h200);

        // Vectored interrupt vs exception
        mtvec = 32'h201; meie = 1; mie = 1;
        ex_valid = 1; ext_irq = 1; pc_ex = 32'h500;
`ifdef TRAP_VECTORED_EN
        trap_seq("vec_ext", 32'h500, 32'h8000_000B, 32'd0, 32'h22C);
`else
        trap_seq("vec_ext", 32'h500, 32'h8000_000B, 32'd0, 32'h200);
`endif
        ex_valid = 1; illegal = 1; pc_ex = 32'h504; inst_ex = 32'h1;
        trap_seq("vec_ill", 32'h504, 32'd2, 32'h1, 32'h200);
        mtvec = 32'h200;

        // Reset mid-flush
        ex_valid = 1; illegal = 1; pc_ex = 32'h600; inst_ex = 32'h77;
        tick();
        check_eq("rmid_busy_pre", 32'(trap_busy), 32'd1);
        clear_req();
        rst_n = 0;
        #1;
        check_eq("rmid_busy",   32'(trap_busy), 32'd0);
        check_eq("rmid_flush",  32'(pipe_flush), 32'd0);
        check_eq("rmid_stall",  32'(pipe_stall), 32'd0);
        check_eq("rmid_gexc",   32'(g_exception), 32'd0);
        check_eq("rmid_mepc",   mepc_wdata, 32'd0);
        check_eq("rmid_mcause", mcause_wdata, 32'd0);
        repeat (2) tick();
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("rpost_we",   32'(trap_csr_we), 32'd0);
            check_eq("rpost_busy", 32'(trap_busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap controller for the RV32I core; consumes qualified EX-stage exception flags and level interrupt lines.
- Arbitrates between simultaneous trap sources, sequences pipeline stall/flush, issues one CSR trap-update strobe and a PC redirect to mtvec.
- Also sequences mret (redirect to mepc, restore MIE).
- Sits between the EX stage, the CSR unit and the fetch PC mux; drives g_exception for the rest of the pipeline.

Parameters:
- FLUSH_CYCLES, 2, cycles pipe_flush is held; range 1..15; 4-bit down-counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- ex_valid  in  1  EX stage holds a valid instruction
- illegal_ops_ex  in  1  illegal instruction in EX
- ecall_ex  in  1  ecall in EX
- ebreak_ex  in  1  ebreak in EX
- mret_ex  in  1  mret in EX
- pc_ex  in  32  PC of EX instruction
- inst_ex  in  32  instruction word in EX
- ext_irq  in  1  external interrupt line, level
- tmr_irq  in  1  timer interrupt line, level
- sw_irq  in  1  software interrupt line, level
- csr_mstatus_mie  in  1  global interrupt enable
- csr_meie  in  1  external interrupt enable
- csr_mtie  in  1  timer interrupt enable
- csr_msie  in  1  software interrupt enable
- csr_mtvec  in  32  trap vector
- csr_mepc  in  32  return address
- g_exception  out  1  trap accepted pulse
- trap_busy  out  1  sequencer not idle
- pipe_stall  out  1  hold IF/ID
- pipe_flush  out  1  squash IF..EX
- trap_csr_we  out  1  write mepc/mcause/mtval
- mepc_wdata  out  32  value for mepc
- mcause_wdata  out  32  value for mcause
- mtval_wdata  out  32  value for mtval
- mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0
- mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1
- pc_redirect  out  1  load PC
- pc_redirect_addr  out  32  new PC

Interface:
- One clock, clk; reset rst_n is asynchronous, active-low.
- All outputs are registered or decoded from registered state only.

Behaviour:
- States: IDLE, FLUSH, CSRW, REDIR.
- Reset (async, any state): state=IDLE; counter=0; all outputs and captured registers 0. A reset mid-sequence leaves no partial CSR write.
- Acceptance: requests are sampled only in IDLE with ex_valid=1. In all other states requests are ignored; the pipeline is stalled or flushed there.
- Priority and encoding:
  - illegal: mcause=2, mtval=inst_ex
  - ecall: mcause=11, mtval=0
  - ebreak: mcause=3, mtval=pc_ex
  - otherwise interrupt, taken only if csr_mstatus_mie=1:
    - ext_irq&csr_meie: mcause=0x8000000B
    - sw_irq&csr_msie: mcause=0x80000003
    - tmr_irq&csr_mtie: mcause=0x80000007
    - all interrupts: mtval=0
  - otherwise mret_ex.
- mepc_wdata = pc_ex for every trap. On an interrupt the EX instruction is flushed and re-executed after return.
- Exception and mret in the same cycle: exception wins, and the mret is not performed.
- Trap accept in cycle T:
  - T+1: g_exception=1 for 1 cycle; state=FLUSH; counter=FLUSH_CYCLES.
  - FLUSH: pipe_flush=1, pipe_stall=1; counter decrements; at 1 go to CSRW.
  - CSRW (1 cycle): trap_csr_we=1, mstatus_trap=1, pipe_stall=1, data outputs valid.
  - REDIR (1 cycle): pc_redirect=1, pc_redirect_addr = {csr_mtvec[31:2],2'b00}, pipe_stall=1; then IDLE.
- mret accept in cycle T:
  - T+1: FLUSH as above, with g_exception=0.
  - Then skip CSRW and go straight to REDIR: pc_redirect=1, pc_redirect_addr={csr_mepc[31:2],2'b00}, mstatus_mret=1 in the same cycle.
- trap_busy=1 whenever state != IDLE.
- Latency:
  - Trap: accept to redirect = FLUSH_CYCLES+2 cycles.
  - mret: accept to redirect = FLUSH_CYCLES+1 cycles.
- Back-to-back: a new request may be accepted in the first IDLE cycle after REDIR. A pending interrupt is re-evaluated there against the already-updated MIE.
- Interrupt lines are level-sensitive and are not latched; an interrupt deasserted before acceptance is lost.
- Data registers mepc_wdata, mcause_wdata and mtval_wdata hold their value until the next accept.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: if csr_mtvec[1:0]==2'b01 and the trap is an interrupt, pc_redirect_addr = base + 4*mcause[30:0]. Exceptions always use base.
- Undefined: mtvec mode bits are ignored and all traps go to base.

Test Plan:
- Illegal op: ex_valid=1, illegal_ops_ex=1, pc_ex=0x100, inst_ex=0xFFFFFFFF, FLUSH_CYCLES=2 -> g_exception at T+1; flush T+1..T+2; CSRW at T+3 with mepc=0x100, mcause=2, mtval=0xFFFFFFFF; redirect at T+4 to 0x200 (mtvec=0x200).
- Priority: illegal+ecall+ext_irq same cycle, MIE=1 -> mcause=2. Separately ecall+tmr_irq -> mcause=11. Separately sw_irq+tmr_irq (msie=mtie=1) -> mcause=0x80000003.
- Masking: tmr_irq=1, mtie=1, mstatus_mie=0 -> no activity for 20 cycles. Setting mstatus_mie=1 -> trap with mcause=0x80000007, mtval=0.
- mret: csr_mepc=0x1234, mret_ex=1 -> no trap_csr_we; redirect to 0x1234 with mstatus_mret at T+3; mret+illegal same cycle -> illegal trap only.
- Reset mid-flush: assert rst_n=0 in FLUSH -> all outputs 0 immediately; after release, state is IDLE and no trap_csr_we is ever seen.
- TRAP_VECTORED_EN: mtvec=0x201, ext_irq -> redirect 0x22C; illegal -> redirect 0x200. Without the macro both redirect to 0x200.
